// File: rtl/mac8_fir.sv
// mac8_fir: 8-tap symmetric (linear-phase) FIR filter for a signed int8 stream.
// A new sample is accepted on every clock. The registered 16-bit result covers
// the current input and the 7 previous samples held in the delay line.
// Symmetric taps share a multiplier through a 9-bit pre-adder. The exact
// 20-bit sum is arithmetically shifted and then saturated to 16 bits.
module mac8_fir #(
  parameter int H0    = -3,
  parameter int H1    = 10,
  parameter int H2    = 40,
  parameter int H3    = 80,
  parameter int SHIFT = 0
) (
  input  logic              clk,
  input  logic              RstN,  // active-high asynchronous reset despite the name
  input  logic signed [7:0] X,
  output logic signed [15:0] Yn
);

  localparam logic signed [7:0] H0_C = 8'(H0);
  localparam logic signed [7:0] H1_C = 8'(H1);
  localparam logic signed [7:0] H2_C = 8'(H2);
  localparam logic signed [7:0] H3_C = 8'(H3);

  localparam logic signed [19:0] SAT_MAX = 20'sd32767;
  localparam logic signed [19:0] SAT_MIN = -20'sd32768;

  // Delay line: dly_q[k] holds x[n-k] as seen by the combinational datapath.
  logic signed [7:0]  dly_q [1:7];
  logic signed [7:0]  dly_d [1:7];

  logic signed [8:0]  s0, s1, s2, s3;
  logic signed [16:0] p0, p1, p2, p3;
  logic signed [19:0] acc;
  logic signed [19:0] acc_s;
  logic signed [15:0] y_d;
  logic signed [15:0] y_q;

  // Shift the delay line by one sample per clock, with the live input entering at tap 1.
  always_comb begin
    dly_d[1] = X;
    for (int k = 2; k <= 7; k++) begin
      dly_d[k] = dly_q[k-1];
    end
  end

  // Pre-add symmetric tap pairs. The 9-bit width holds the sum of two int8 values exactly.
  always_comb begin
    s0 = 9'(X)        + 9'(dly_q[7]);
    s1 = 9'(dly_q[1]) + 9'(dly_q[6]);
    s2 = 9'(dly_q[2]) + 9'(dly_q[5]);
    s3 = 9'(dly_q[3]) + 9'(dly_q[4]);
  end

  // Multiply with 17-bit operands so that the products come out signed and exact.
  always_comb begin
    p0 = 17'(s0) * 17'(H0_C);
    p1 = 17'(s1) * 17'(H1_C);
    p2 = 17'(s2) * 17'(H2_C);
    p3 = 17'(s3) * 17'(H3_C);
  end

  // Sum the products in a two-level tree. 20 bits cannot overflow for four 17-bit terms.
  always_comb begin
    acc = (20'(p0) + 20'(p1)) + (20'(p2) + 20'(p3));
  end

  // Apply the arithmetic right shift, which floors, then clamp to the 16-bit output range.
  always_comb begin
    acc_s = acc >>> SHIFT;
    if (acc_s > SAT_MAX) begin
      y_d = 16'sh7fff;
    end else if (acc_s < SAT_MIN) begin
      y_d = -16'sh8000;
    end else begin
      y_d = acc_s[15:0];
    end
  end

  // Register the delay line and the output. Reset clears all history immediately.
  always_ff @(posedge clk or posedge RstN) begin
    if (RstN) begin
      for (int k = 1; k <= 7; k++) begin
        dly_q[k] <= '0;
      end
      y_q <= '0;
    end else begin
      for (int k = 1; k <= 7; k++) begin
        dly_q[k] <= dly_d[k];
      end
      y_q <= y_d;
    end
  end

  assign Yn = y_q;

endmodule

// File: tb/tb_mac8_fir.sv
// tb_mac8_fir: directed checks of the mac8_fir filter.
// Covers reset, asynchronous reset, impulse, step, negative step and saturation,
// plus a pseudo-random stream checked against a convolution model.
module tb_mac8_fir;

  logic              clk = 1'b0;
  logic              RstN;
  logic signed [7:0] X;
  logic signed [15:0] Yn;

  int n_checks = 0;
  int n_fail   = 0;

  mac8_fir dut (
    .clk  (clk),
    .RstN (RstN),
    .X    (X),
    .Yn   (Yn)
  );

  always #5 clk = ~clk;

  // Assert reset for one clock and release it on a falling edge, leaving the filter clean.
  task automatic do_reset();
    @(negedge clk);
    RstN = 1'b1;
    X    = 8'sd0;
    @(negedge clk);
    RstN = 1'b0;
  endtask

  task automatic test_reset();
    RstN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      X = (i % 2 == 0) ? 8'sd55 : -8'sd55;
      @(negedge clk);
      n_checks++;
      if (Yn !== 16'sd0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: Yn=%0d expected 0", i, Yn);
      end
    end
    RstN = 1'b0;
    X    = 8'sd0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      X = 8'sd127;
      @(negedge clk);
    end
    n_checks++;
    if (Yn !== 16'sd16129) begin
      n_fail++;
      $display("FAIL async_pre Yn=%0d expected 16129", Yn);
    end
    #2 RstN = 1'b1;
    #1;
    n_checks++;
    if (Yn !== 16'sd0) begin
      n_fail++;
      $display("FAIL async_clear Yn=%0d expected 0 before next edge", Yn);
    end
    @(negedge clk);
    RstN = 1'b0;
    X    = 8'sd0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_checks++;
      if (Yn !== 16'sd0) begin
        n_fail++;
        $display("FAIL async_history cycle %0d: Yn=%0d expected 0", i, Yn);
      end
    end
  endtask

  task automatic test_impulse();
    int exp_y[12] = '{-3, 10, 40, 80, 80, 40, 10, -3, 0, 0, 0, 0};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      X = (i == 0) ? 8'sd1 : 8'sd0;
      @(negedge clk);
      n_checks++;
      if (Yn !== 16'(exp_y[i])) begin
        n_fail++;
        $display("FAIL impulse[%0d]: Yn=%0d expected %0d", i, Yn, exp_y[i]);
      end
    end
  endtask

  task automatic test_step();
    int exp_y[10] = '{-381, 889, 5969, 16129, 26289, 31369, 32639, 32258, 32258, 32258};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      X = 8'sd127;
      @(negedge clk);
      n_checks++;
      if (Yn !== 16'(exp_y[i])) begin
        n_fail++;
        $display("FAIL step[%0d]: Yn=%0d expected %0d", i, Yn, exp_y[i]);
      end
    end
  endtask

  task automatic test_neg_step();
    // The seventh ramp value, -128*257 = -32896, clamps. The steady state does not.
    int exp_y[10] = '{384, -896, -6016, -16256, -26496, -31616, -32768, -32512, -32512, -32512};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      X = -8'sd128;
      @(negedge clk);
      n_checks++;
      if (Yn !== 16'(exp_y[i])) begin
        n_fail++;
        $display("FAIL neg_step[%0d]: Yn=%0d expected %0d", i, Yn, exp_y[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int xs[9] = '{-128, 127, 127, 127, 127, 127, 127, -128, 0};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      X = 8'(xs[i]);
      @(negedge clk);
      if (i == 7) begin
        // The exact sum is 768+2540+10160+20320 = 33788, which clamps.
        n_checks++;
        if (Yn !== 16'sd32767) begin
          n_fail++;
          $display("FAIL saturation_pos: Yn=%0d expected 32767", Yn);
        end
      end else if (i == 8) begin
        // Computed as -3*127 + 10*(-1) + 40*254 + 80*254.
        n_checks++;
        if (Yn !== 16'sd30089) begin
          n_fail++;
          $display("FAIL saturation_after: Yn=%0d expected 30089", Yn);
        end
      end
    end
  endtask

  task automatic test_stream();
    int h[8] = '{-3, 10, 40, 80, 80, 40, 10, -3};
    int hist[8];
    int acc;
    int y_exp;
    logic [31:0] seed;
    logic [7:0]  raw;
    seed = 32'h1234_5678;
    for (int k = 0; k < 8; k++) hist[k] = 0;
    do_reset();
    for (int i = 0; i < 176; i++) begin
      seed = seed * 32'd1103515245 + 32'd12345;
      raw  = seed[23:16];
      if (i % 29 == 5) raw = 8'h80;
      if (i % 31 == 7) raw = 8'h7f;
      X = raw;
      for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = int'($signed(raw));
      acc = 0;
      for (int k = 0; k < 8; k++) acc += h[k] * hist[k];
      y_exp = acc >>> 0;
      if (y_exp > 32767)  y_exp = 32767;
      if (y_exp < -32768) y_exp = -32768;
      @(negedge clk);
      n_checks++;
      if (Yn !== 16'(y_exp)) begin
        n_fail++;
        $display("FAIL stream[%0d]: Yn=%0d expected %0d", i, Yn, y_exp);
      end
    end
  endtask

  initial begin
    RstN = 1'b1;
    X    = 8'sd0;
    test_reset();
    test_async_reset();
    test_impulse();
    test_step();
    test_neg_step();
    test_saturation();
    test_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
